// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// Frame state encoding, idle line level and counter sizing helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT enabled cycles.
// Cleared on reset or at frame start so every bit period is exact.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W bits LSB first, stop bit.
// All outputs registered; tx_ready decodes the state register only.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_idx;
  logic              r_out;
  logic              r_busy;

  logic              w_accept;
  logic              w_tick;
  logic [DATA_W-1:0] w_next;

  assign tx_ready = (r_state == IDLE);
  assign tx_out   = r_out;
  assign busy     = r_busy;
  assign w_accept = tx_valid && tx_ready;
  assign w_next   = r_shift >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (r_busy),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_out   <= LINE_IDLE;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (tx_valid) begin
            r_shift <= tx_data;
            r_idx   <= '0;
            r_out   <= ~LINE_IDLE;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_out   <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_BIT) begin
              r_out   <= LINE_IDLE;
              r_state <= STOP;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_shift <= w_next;
              r_out   <= w_next[0];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame-queue model per instance plus literal frames.
// Two instances share stimulus: CLKS_PER_BIT of 4 and of 1.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic rdy0, out0, busy0;
  logic rdy1, out1, busy1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit q0[$];
  bit q1[$];

  bit a5_exp[10]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  bit c3_exp[10]  = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
  bit h81_exp[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};

  always #5 clk = ~clk;

  serial_tx #(
    .CLKS_PER_BIT(4),
    .DATA_W      (8)
  ) u0 (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(rdy0),
    .tx_out  (out0),
    .busy    (busy0)
  );

  serial_tx #(
    .CLKS_PER_BIT(1),
    .DATA_W      (8)
  ) u1 (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(rdy1),
    .tx_out  (out1),
    .busy    (busy1)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for slot s of a frame: 0 start, 1..8 data LSB first, 9 stop
  function automatic bit frame_bit(input logic [7:0] d, input int s);
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return d[s-1];
  endfunction

  // Each queue holds the line level of every remaining frame cycle
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() == 0) begin
        if (tx_valid)
          for (int s = 0; s < 10; s++)
            for (int k = 0; k < 4; k++) q0.push_back(frame_bit(tx_data, s));
      end else begin
        void'(q0.pop_front());
      end
      if (q1.size() == 0) begin
        if (tx_valid)
          for (int s = 0; s < 10; s++) q1.push_back(frame_bit(tx_data, s));
      end else begin
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m0_line", out0, (q0.size() != 0) ? q0[0] : 1'b1);
      check("m0_busy", busy0, q0.size() != 0);
      check("m0_ready", rdy0, q0.size() == 0);
      check("m1_line", out1, (q1.size() != 0) ? q1[0] : 1'b1);
      check("m1_busy", busy1, q1.size() != 0);
      check("m1_ready", rdy1, q1.size() == 0);
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #2;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #2;
    tx_valid = 1'b0;
  endtask

  initial begin
    int lows;
    int lowpos;
    int edges;
    logic prev;

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_line", out0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ready", rdy0, 1'b1);
    chk_en = 1'b1;

    send(8'hA5);
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("a5_line", out0, a5_exp[s]);
        check("a5_busy", busy0, 1'b1);
      end
    @(negedge clk);
    check("a5_end_busy", busy0, 1'b0);
    check("a5_end_line", out0, 1'b1);
    repeat (3) @(negedge clk);

    @(posedge clk);
    #2;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #2;
    tx_data = 8'hFF;
    lows    = 0;
    lowpos  = -1;
    for (int c = 1; c <= 81; c++) begin
      @(negedge clk);
      if (!busy0) begin
        lows++;
        lowpos = c;
      end
      if (c == 6) check("b2b_f1_bit0", out0, 1'b0);
      if (c == 41) check("b2b_gap_line", out0, 1'b1);
      if (c == 46) check("b2b_f2_bit0", out0, 1'b1);
      if (c == 50) tx_valid = 1'b0;
    end
    check("b2b_idle_cnt", lows, 1);
    check("b2b_idle_pos", lowpos, 41);
    repeat (5) @(negedge clk);

    send(8'hC3);
    tx_data = 8'h3C;
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("c3_line", out0, c3_exp[s]);
      end
    repeat (3) @(negedge clk);

    send(8'hA5);
    repeat (18) @(negedge clk);
    check("mid_bit3", out0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_line", out0, 1'b1);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_ready", rdy0, 1'b1);
    prev  = out0;
    edges = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out0 !== prev) edges++;
      prev = out0;
    end
    check("mid_no_edges", edges, 0);

    send(8'h81);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      check("h81_line", out1, h81_exp[s]);
      check("h81_busy", busy1, 1'b1);
    end
    @(negedge clk);
    check("h81_end_busy", busy1, 1'b0);
    check("h81_end_line", out1, 1'b1);
    repeat (45) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 1..65535).
REQ-002 SHALL have parameter DATA_W, default 8, payload bits per frame (legal range 1..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_data  input  DATA_W  parallel payload, sampled only on acceptance.
REQ-006 SHALL have port tx_valid  input  1  payload offered.
REQ-007 SHALL have port tx_ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port tx_out  output  1  serial line; idle level high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 SHALL drive tx_ready = 1 only in IDLE, decoded from registered state with no combinational path from tx_valid.
REQ-013 SHALL accept a payload on a rising edge where tx_valid && tx_ready, capturing tx_data into an internal shift register and entering START.
REQ-014 SHALL ignore tx_data changes after acceptance; the transmitted frame equals the captured word.
REQ-015 SHALL hold tx_out = 0 for exactly CLKS_PER_BIT cycles in START, starting the cycle after acceptance.
REQ-016 SHALL in DATA transmit DATA_W bits LSB first, each held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL hold tx_out = 1 for exactly CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-018 SHALL make a frame occupy exactly (DATA_W+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-019 SHALL drive tx_out = 1 in IDLE and after reset.
REQ-020 SHALL assert busy in START, DATA and STOP, and deassert it in IDLE.
REQ-021 SHALL, with tx_valid held high, accept the next payload in the first IDLE cycle, giving exactly one idle-high cycle between consecutive frames.
REQ-022 SHALL, with CLKS_PER_BIT = 1, change bits every cycle with no extra cycles.
REQ-023 SHALL size the bit-period counter to ceil(log2(CLKS_PER_BIT)) bits, minimum 1, and wrap it to 0 at CLKS_PER_BIT-1.
REQ-024 SHALL size the bit index counter to hold 0..DATA_W-1, with DATA-to-STOP on the last tick of bit DATA_W-1.
REQ-025 SHALL register tx_out (no glitches from state decode).

Reset
REQ-026 SHALL, on rst high at a rising edge, set state IDLE, tx_out = 1, busy = 0, tx_ready = 1 on the following cycle, and all counters and the shift register to 0.
REQ-027 SHALL, on reset mid-frame, abandon the frame with no stop bit and drive the line high from the next cycle.
REQ-028 SHALL give rst priority over a simultaneous tx_valid; no payload is accepted in a reset cycle.

Structure
REQ-029 SHALL place the state enumeration (IDLE, START, DATA, STOP) and the idle line level constant in shared package serial_pkg, for reuse by the matching receiver.
REQ-030 SHALL instantiate one sub-module, bit_timer: a counter that emits a one-cycle tick every CLKS_PER_BIT cycles and is cleared on rst or on frame start.

Verification
REQ-031 SHALL cover: defaults, rst 1 for 2 cycles then 0 -> tx_out = 1, busy = 0, tx_ready = 1.
REQ-032 SHALL cover: tx_data = 8'hA5, one-cycle tx_valid -> line 0,1,0,1,0,0,1,0,1,1, each 4 cycles, 40 cycles total.
REQ-033 SHALL cover: tx_valid held with 8'h00 then 8'hFF -> two frames separated by exactly 1 idle-high cycle, busy low only in that cycle.
REQ-034 SHALL cover: tx_data changed to 8'h3C one cycle after accepting 8'hC3 -> the transmitted bits are those of 8'hC3.
REQ-035 SHALL cover: rst pulsed during data bit 3 -> tx_out = 1 and busy = 0 next cycle, no further edges until a new tx_valid.
REQ-036 SHALL cover: CLKS_PER_BIT = 1 with 8'h81 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1.
